// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared FSM state type and sizing constants for the ECC job arbiter
package ecc_pkg;

  // Nibbles per 32-bit operand/result word.
  localparam int NIBBLES = 8;

  // Default number of WAIT cycles before a job is aborted.
  localparam int TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/ecc_nibble_shift.sv
// rtl/ecc_nibble_shift.sv - multi-lane 32-bit word register with LSB-first nibble shift-out and shift-in
//   clk, rst    : clock, synchronous active-high reset
//   load        : parallel load of every lane from load_data
//   shift       : shift every lane right by one nibble, shift_in entering at the top
//   nib_out     : current low nibble of each lane
//   data        : full register contents
module ecc_nibble_shift
  import ecc_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [LANES-1:0][NIBBLES*4-1:0]  load_data,
  input  logic                             shift,
  input  logic [LANES-1:0][3:0]            shift_in,
  output logic [LANES-1:0][3:0]            nib_out,
  output logic [LANES-1:0][NIBBLES*4-1:0]  data
);

  logic [LANES-1:0][NIBBLES*4-1:0] q;

  // A right shift emits the LSB nibble first; after NIBBLES shifts the
  // first nibble shifted in has arrived at bits [3:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      for (int l = 0; l < LANES; l++) begin
        q[l] <= {shift_in[l], q[l][NIBBLES*4-1:4]};
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign nib_out[l] = q[l][3:0];
  end

  assign data = q;

endmodule

// File: rtl/ecc_job_arbiter.sv
// rtl/ecc_job_arbiter.sv - two-requester round-robin job arbiter feeding a nibble-serial ECC core
//   i_clk, i_rst          : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester job handshake (ready is one-hot, IDLE only)
//   req_a..req_py         : 2x32 packed operands, requester r in bits [32r+31:32r]
//   rsp_valid/rsp_ready   : result handshake; rsp_id, rsp_x, rsp_y, rsp_err result payload
//   core_start, core_a..  : operand nibble stream to the core (LSB nibble first)
//   core_kpx/kpy, core_done : result nibble stream and completion pulse from the core
module ecc_job_arbiter
  import ecc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int NIB     = NIBBLES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_prime,
  input  logic [63:0] req_k,
  input  logic [63:0] req_px,
  input  logic [63:0] req_py,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_x,
  output logic [31:0] rsp_y,
  output logic        rsp_err,
  output logic        core_start,
  output logic [3:0]  core_a,
  output logic [3:0]  core_prime,
  output logic [3:0]  core_k,
  output logic [3:0]  core_px,
  output logic [3:0]  core_py,
  input  logic [3:0]  core_kpx,
  input  logic [3:0]  core_kpy,
  input  logic        core_done
);

  localparam int CW = $clog2(TIMEOUT + NIB);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            last_gnt;
  logic            gnt;
  logic            accept;
  logic            job_id;
  logic            job_err;
  logic            nib_last;
  logic            wait_expired;
  logic [5:0]      sel_base;
  logic [4:0][31:0] op_load;
  logic [4:0][3:0]  shift_in;
  logic [4:0][3:0]  shift_nib;
  logic [4:0][31:0] shift_data;
  logic            unused_lanes;

  // With exactly one requester valid it wins outright; otherwise the one
  // not granted last is offered (last_gnt resets to 1 so requester 0 leads).
  assign gnt      = (req_valid[0] ^ req_valid[1]) ? req_valid[1] : ~last_gnt;
  assign accept   = |(req_valid & req_ready);
  assign sel_base = gnt ? 6'd32 : 6'd0;

  assign nib_last     = (cnt == CW'(NIB - 1));
  assign wait_expired = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = gnt ? 2'b10 : 2'b01;
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        core_start = 1'b1;
        if (nib_last) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done)         state_nxt = ST_UNLOAD;
        else if (wait_expired) state_nxt = ST_RESP;
      end
      ST_UNLOAD: begin
        if (nib_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One counter serves LOAD, WAIT and UNLOAD; it restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      job_id   <= 1'b0;
      job_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        job_id   <= gnt;
        last_gnt <= gnt;
        job_err  <= 1'b0;
      end
      if (state == ST_WAIT && !core_done && wait_expired) job_err <= 1'b1;
    end
  end

  // One register bank carries the operands out during LOAD (zero-filling as it
  // goes) and then collects the result into lanes 0/1 during UNLOAD. A timed-out
  // job therefore reports zero coordinates without extra clearing.
  assign op_load = {req_py[sel_base +: 32], req_px[sel_base +: 32], req_k[sel_base +: 32],
                    req_prime[sel_base +: 32], req_a[sel_base +: 32]};
  assign shift_in = (state == ST_UNLOAD) ? {12'd0, core_kpy, core_kpx} : '0;

  ecc_nibble_shift #(.LANES(5)) u_shift (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept),
    .load_data (op_load),
    .shift     ((state == ST_LOAD) || (state == ST_UNLOAD)),
    .shift_in  (shift_in),
    .nib_out   (shift_nib),
    .data      (shift_data)
  );

  assign unused_lanes = ^shift_data[4:2];

  // Lanes 0/1 hold result nibbles during UNLOAD, so the operand ports are gated.
  assign core_a     = core_start ? shift_nib[0] : 4'd0;
  assign core_prime = core_start ? shift_nib[1] : 4'd0;
  assign core_k     = core_start ? shift_nib[2] : 4'd0;
  assign core_px    = core_start ? shift_nib[3] : 4'd0;
  assign core_py    = core_start ? shift_nib[4] : 4'd0;

  assign rsp_id  = rsp_valid & job_id;
  assign rsp_err = rsp_valid & job_err;
  assign rsp_x   = rsp_valid ? shift_data[0] : 32'd0;
  assign rsp_y   = rsp_valid ? shift_data[1] : 32'd0;

endmodule
